// File: rtl/interrupt_controller.sv
// Interrupt priority / acknowledge block for the MAXI030 glue logic.
// Synchronises and masks seven request levels and answers 68030 IACK cycles with IACK, AVEC or BERR.
module interrupt_controller #(
    parameter logic [6:0] VECTORED = 7'b0000100,
    parameter logic [7:0] TIMEOUT  = 8'd64
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic [6:0] irq_in,
    input  logic       as,
    input  logic [2:0] fc,
    input  logic [3:0] addr_middle,
    input  logic [2:0] addr_level,
    input  logic       write,
    input  logic       cs,
    input  logic [6:0] data_in,
    output logic [2:0] ipl,
    output logic [6:0] iack,
    output logic       avec,
    output logic       berr,
    output logic [6:0] mask,
    output logic [6:0] pending
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEC,
        S_AUTO,
        S_SPUR,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] r_mask;
    logic [6:0] w_pending;

    logic [2:0] r_ipl;
    logic [2:0] w_next_ipl;

    logic [7:0] r_count;
    logic [7:0] w_next_count;

    logic [6:0] r_lvl_onehot;
    logic [6:0] w_level_sel;
    logic       w_lvl_pending;
    logic       w_lvl_vectored;
    logic       w_iack_cyc;

    logic [6:0] r_iack;
    logic       r_avec;
    logic       r_berr;

    // Two-flop synchroniser on the asynchronous request lines.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments let the second flop take the first flop's old value, forming a real two-stage chain.
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_mask <= '0;
        end else if (cs && write) begin
            r_mask <= data_in;
        end
    end

    assign w_pending = r_sync2 & r_mask;

    // Ascending scan: the last set bit seen, i.e. the highest level, wins.
    always_comb begin
        // NOTE: default first so every path assigns the result and no latch is inferred.
        w_next_ipl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (w_pending[i]) begin
                w_next_ipl = 3'(i + 1);
            end
        end
    end

    assign w_iack_cyc = as && (fc == 3'b111) && (addr_middle == 4'hF);

    // Level 0 selects nothing, so it reads as "not pending" and becomes spurious.
    always_comb begin
        w_level_sel = '0;
        if (addr_level != 3'd0) begin
            w_level_sel = 7'd1 << (addr_level - 3'd1);
        end
    end

    assign w_lvl_pending  = |(w_level_sel & w_pending);
    assign w_lvl_vectored = |(w_level_sel & VECTORED);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                w_next_count = '0;
                if (w_iack_cyc) begin
                    if (!w_lvl_pending) begin
                        w_next_state = S_SPUR;
                    end else if (w_lvl_vectored) begin
                        w_next_state = S_VEC;
                    end else begin
                        w_next_state = S_AUTO;
                    end
                end
            end
            S_VEC: begin
                w_next_count = r_count + 8'd1;
                if (!as) begin
                    w_next_state = S_DONE;
                end else if (r_count == TIMEOUT - 8'd1) begin
                    w_next_state = S_SPUR;
                end
            end
            S_AUTO, S_SPUR: begin
                if (!as) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_count = '0;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_count = '0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The acknowledged level is latched once so a changing addr_level cannot move the strobe.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_lvl_onehot <= '0;
        end else if (r_state == S_IDLE && w_iack_cyc) begin
            r_lvl_onehot <= w_level_sel;
        end
    end

    // ipl is frozen outside IDLE so the presented level cannot change mid-acknowledge.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_ipl <= '0;
        end else if (r_state == S_IDLE) begin
            r_ipl <= w_next_ipl;
        end
    end

    // Strobes follow the state one clock later and clear asynchronously on reset.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_iack <= '0;
            r_avec <= 1'b0;
            r_berr <= 1'b0;
        end else begin
            r_iack <= (r_state == S_VEC) ? r_lvl_onehot : 7'd0;
            r_avec <= (r_state == S_AUTO);
            r_berr <= (r_state == S_SPUR);
        end
    end

    assign ipl     = r_ipl;
    assign iack    = r_iack;
    assign avec    = r_avec;
    assign berr    = r_berr;
    assign mask    = r_mask;
    assign pending = w_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a timeline model of each acknowledge is compared every cycle,
// plus literal checks pinning reset, latency, strobe and timeout behaviour.
module tb_interrupt_controller;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic [6:0] irq_in = '0;
    logic       as = 1'b0;
    logic [2:0] fc = '0;
    logic [3:0] addr_middle = '0;
    logic [2:0] addr_level = '0;
    logic       write = 1'b0;
    logic       cs = 1'b0;
    logic [6:0] data_in = '0;
    logic [2:0] ipl;
    logic [6:0] iack;
    logic       avec;
    logic       berr;
    logic [6:0] mask;
    logic [6:0] pending;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    interrupt_controller dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .irq_in      (irq_in),
        .as          (as),
        .fc          (fc),
        .addr_middle (addr_middle),
        .addr_level  (addr_level),
        .write       (write),
        .cs          (cs),
        .data_in     (data_in),
        .ipl         (ipl),
        .iack        (iack),
        .avec        (avec),
        .berr        (berr),
        .mask        (mask),
        .pending     (pending)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {K_VEC, K_AUTO, K_SPUR} kind_t;

    localparam logic [6:0] M_VECTORED = 7'b0000100;
    localparam int         M_TIMEOUT  = 64;

    logic [6:0] m_hist1 = '0, m_hist2 = '0, m_mask = '0;
    logic [2:0] e_ipl = '0;
    logic [6:0] e_iack = '0, e_pending = '0;
    logic       e_avec = 1'b0, e_berr = 1'b0;
    int         m_n = 0, m_a = 0, m_l = -1;
    bit         m_have_ack = 1'b0;
    kind_t      m_kind = K_SPUR;
    logic [2:0] m_lvl = '0;

    function automatic logic [2:0] highest(input logic [6:0] p);
        logic [2:0] r = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (p[i] && r == 3'd0) r = 3'(i + 1);
        end
        return r;
    endfunction

    // Edge n: an acknowledge accepted at edge A and whose as-low is first seen at edge L
    // drives its strobe on edges A+1..L and blocks IDLE until edge L+2.
    always @(posedge clock or negedge n_reset) begin
        logic [6:0] pend_before;
        bit         busy;
        if (!n_reset) begin
            m_hist1 = '0; m_hist2 = '0; m_mask = '0;
            e_ipl = '0; e_iack = '0; e_avec = 1'b0; e_berr = 1'b0; e_pending = '0;
            m_n = 0; m_a = 0; m_l = -1; m_have_ack = 1'b0;
        end else begin
            m_n++;
            pend_before = m_hist2 & m_mask;
            busy = m_have_ack && (m_l < 0 || m_n <= m_l + 1);
            if (!busy) e_ipl = highest(pend_before);
            if (!busy && as && fc == 3'd7 && addr_middle == 4'hF) begin
                m_have_ack = 1'b1;
                m_a = m_n;
                m_l = -1;
                m_lvl = addr_level;
                if (addr_level == 3'd0 || !pend_before[addr_level - 3'd1]) m_kind = K_SPUR;
                else if (M_VECTORED[addr_level - 3'd1]) m_kind = K_VEC;
                else m_kind = K_AUTO;
            end else if (busy && m_l < 0 && !as) begin
                m_l = m_n;
            end
            e_iack = '0; e_avec = 1'b0; e_berr = 1'b0;
            if (m_have_ack && m_n > m_a && (m_l < 0 || m_n <= m_l)) begin
                case (m_kind)
                    K_VEC: begin
                        if (m_n - m_a <= M_TIMEOUT) e_iack = 7'd1 << (m_lvl - 3'd1);
                        else e_berr = 1'b1;
                    end
                    K_AUTO: e_avec = 1'b1;
                    default: e_berr = 1'b1;
                endcase
            end
            if (cs && write) m_mask = data_in;
            m_hist2 = m_hist1;
            m_hist1 = irq_in;
            e_pending = m_hist2 & m_mask;
        end
    end

    always @(negedge clock) begin
        if (cmp_en && n_reset) begin
            check("cyc_ipl", {5'd0, ipl}, {5'd0, e_ipl});
            check("cyc_iack", {1'b0, iack}, {1'b0, e_iack});
            check("cyc_avec", {7'd0, avec}, {7'd0, e_avec});
            check("cyc_berr", {7'd0, berr}, {7'd0, e_berr});
            check("cyc_mask", {1'b0, mask}, {1'b0, m_mask});
            check("cyc_pending", {1'b0, pending}, {1'b0, e_pending});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_mask(input logic [6:0] v);
        cs = 1'b1; write = 1'b1; data_in = v;
        tick();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic ack_start(input logic [2:0] lvl);
        as = 1'b1; fc = 3'd7; addr_middle = 4'hF; addr_level = lvl;
    endtask

    task automatic ack_end();
        as = 1'b0; fc = 3'd0; addr_middle = 4'h0;
    endtask

    initial begin
        int iack_cycles;
        int berr_cycles;

        // Reset with every request raised.
        irq_in = 7'h7F;
        tick();
        check("rst_ipl", {5'd0, ipl}, 8'd0);
        check("rst_iack", {1'b0, iack}, 8'd0);
        check("rst_avec", {7'd0, avec}, 8'd0);
        check("rst_berr", {7'd0, berr}, 8'd0);
        check("rst_mask", {1'b0, mask}, 8'd0);
        tick(2);
        n_reset = 1'b1;
        cmp_en = 1'b1;
        tick(4);
        check("rst_pending", {1'b0, pending}, 8'd0);
        irq_in = '0;
        tick(3);

        // Priority encode and its 3-clock latency.
        write_mask(7'h7F);
        check("mask_wr", {1'b0, mask}, 8'h7F);
        tick(3);
        irq_in = 7'b0010010;
        tick(2);
        check("ipl_lat2", {5'd0, ipl}, 8'd0);
        tick();
        check("ipl_lat3", {5'd0, ipl}, 8'd5);
        irq_in = 7'b0000010;
        tick(3);
        check("ipl_drop", {5'd0, ipl}, 8'd2);

        // Vectored level 3, with a mask write and a new NMI arriving mid-acknowledge.
        write_mask(7'h04);
        irq_in = 7'b0000100;
        tick(3);
        check("vec_ipl", {5'd0, ipl}, 8'd3);
        ack_start(3'd3);
        tick();
        tick();
        check("vec_iack", {1'b0, iack}, 8'h04);
        check("vec_avec", {7'd0, avec}, 8'd0);
        irq_in = 7'b1000100;
        write_mask(7'h44);
        check("vec_mask_mid", {1'b0, mask}, 8'h44);
        tick(2);
        check("vec_hold", {1'b0, iack}, 8'h04);
        check("vec_frozen", {5'd0, ipl}, 8'd3);
        ack_end();
        tick();
        check("vec_as_low", {1'b0, iack}, 8'h04);
        tick();
        check("vec_release", {1'b0, iack}, 8'd0);
        check("vec_done_ipl", {5'd0, ipl}, 8'd3);
        tick();
        check("nmi_after", {5'd0, ipl}, 8'd7);

        // Autovectored level 1.
        irq_in = 7'b0000001;
        write_mask(7'h01);
        tick(3);
        ack_start(3'd1);
        tick(2);
        check("auto_avec", {7'd0, avec}, 8'd1);
        check("auto_iack", {1'b0, iack}, 8'd0);
        check("auto_berr", {7'd0, berr}, 8'd0);
        tick(2);
        ack_end();
        tick(2);
        check("auto_release", {7'd0, avec}, 8'd0);
        tick();

        // Spurious: unpending level 6, then level 0.
        ack_start(3'd6);
        tick(2);
        check("spur6_berr", {7'd0, berr}, 8'd1);
        check("spur6_iack", {1'b0, iack}, 8'd0);
        check("spur6_avec", {7'd0, avec}, 8'd0);
        ack_end();
        tick(3);
        ack_start(3'd0);
        tick(2);
        check("spur0_berr", {7'd0, berr}, 8'd1);
        check("spur0_avec", {7'd0, avec}, 8'd0);
        ack_end();
        tick(3);

        // Silent vectored device: timeout, then reset mid-acknowledge.
        write_mask(7'h04);
        irq_in = 7'b0000100;
        tick(3);
        ack_start(3'd3);
        tick();
        iack_cycles = 0;
        berr_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (iack == 7'b0000100) iack_cycles++;
            if (berr) berr_cycles++;
        end
        check("to_iack_cycles", 8'(iack_cycles), 8'd64);
        check("to_berr_cycles", 8'(berr_cycles), 8'd36);
        n_reset = 1'b0;
        #1;
        check("arst_iack", {1'b0, iack}, 8'd0);
        check("arst_berr", {7'd0, berr}, 8'd0);
        check("arst_avec", {7'd0, avec}, 8'd0);
        check("arst_ipl", {5'd0, ipl}, 8'd0);
        check("arst_mask", {1'b0, mask}, 8'd0);
        ack_end();
        tick(2);
        n_reset = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Interrupt priority and acknowledge block for the MAXI030 glue logic.
- Sits upstream of the 68030 interrupt pins and replaces the core's fixed n_ipl/n_avec/n_iacke/n_quart_iack placeholders.
- Synchronises seven active-high request lines, applies a CPU-writable mask, and presents the highest pending level.
- During interrupt-acknowledge bus cycles it issues either a per-level IACK strobe (vectored devices) or AVEC, with a bus-error timeout for silent devices.

Parameters:
- VECTORED, 7'b0000100: bit n set = level n+1 is vectored (device supplies the vector via IACK/DSACK); clear = autovector. Default makes level 3 (QUART) vectored.
- TIMEOUT, 8'd64: clocks a vectored IACK may stay unanswered before berr is asserted.

Ports:
- clock  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- irq_in  in  7  raw active-high requests; bit n = level n+1; asynchronous to clock
- as  in  1  address strobe, positive logic
- fc  in  3  CPU function code
- addr_middle  in  4  addr[19:16]
- addr_level  in  3  addr[3:1]; level being acknowledged
- write  in  1  ds & ~rn_w
- cs  in  1  register8 select for the mask register
- data_in  in  7  data[30:24]
- ipl  out  3  encoded pending level, positive logic (core drives n_ipl = ~ipl)
- iack  out  7  one-hot acknowledge; bit n for level n+1
- avec  out  1  autovector request (core drives n_avec = ~avec)
- berr  out  1  spurious or timed-out acknowledge (ORed into n_berr by core)
- mask  out  7  mask register, for readback
- pending  out  7  synchronised & mask, for readback

Behaviour:
- Reset (asynchronous, n_reset low):
  - mask = 0 (all levels disabled); synchronisers cleared.
  - ipl = 0; iack = 0; avec = 0; berr = 0.
  - State = IDLE; timeout counter = 0.
- Synchroniser: two flops per irq_in bit. pending = sync2 & mask, registered, so pending lags irq_in by 2 clocks.
- Mask write: on each rising clock with cs & write, mask <= data_in. Repeated writes within one cycle are harmless.
- Priority encode: next_ipl = index+1 of the highest set pending bit, 0 if none. ipl is registered from next_ipl, so irq_in to ipl latency is 3 clocks. ipl updates only in IDLE; it is frozen in all other states so the level cannot change mid-acknowledge.
- IACK detect: iack_cyc = as & fc==3'b111 & addr_middle==4'hF.
- State machine:
  - IDLE: on iack_cyc, latch lvl = addr_level.
    - If lvl==0, or pending[lvl-1]==0 → SPUR.
    - Else if VECTORED[lvl-1] → VEC.
    - Else → AUTO.
  - VEC: iack[lvl-1]=1; counter increments each clock.
    - !as → DONE.
    - counter==TIMEOUT-1 → SPUR.
  - AUTO: avec=1 until !as → DONE.
  - SPUR: berr=1; iack=0; avec=0 until !as → DONE.
  - DONE: all strobes 0; counter cleared; → IDLE next clock. This guarantees one idle cycle between acknowledges.
- Outputs are registered and asserted 1 clock after entry into the state; they deassert the clock after as is seen low.
- Simultaneous events:
  - Mask write during an acknowledge takes effect on the mask immediately; ipl reflects it on return to IDLE.
  - An irq_in drop mid-acknowledge does not abort the acknowledge.
  - A new higher-priority request during an acknowledge is presented after DONE.
- Level 7 (NMI) is maskable like the others. Software must set mask bit 6.
- n_reset asserted mid-acknowledge drops every strobe asynchronously.

Test Plan:
- Reset with irq_in=7'h7F → ipl=0, iack=0, avec=0, berr=0, mask=0; pending=0 after 4 clocks.
- Write mask=7'h7F, raise irq_in=7'b0010010 → ipl=3'd5 exactly 3 clocks after irq_in change; drop bit 4 → ipl=3'd2.
- Mask=7'h04, irq_in bit 2 high, IACK cycle with fc=7, addr_middle=F, addr_level=3 → iack=7'b0000100 one clock later, held until as low, then DONE→IDLE; avec=0.
- Mask=7'h01, irq_in bit 0, acknowledge level 1 → avec=1 until as low; iack=0; berr=0.
- Acknowledge level 6 with pending[5]=0 → berr=1 while as held, no iack/avec; acknowledge level 0 → same.
- Vectored level 3 acknowledge with as held 100 clocks → iack high for 64 clocks, then berr=1, iack=0 until as drops; assert n_reset mid-cycle → all outputs 0 same clock.
